// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between NUM_REQ byte producers with packet locking
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          err
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] HOLD      = 3'd4;
  logic [2:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic [PW-1:0] sel;
  logic          lock;
  logic [CW-1:0] cnt;
  logic          do_grant;
  // Rotating search from ptr+1; scanning backwards lets the nearest valid index win
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[idx]) win = idx;
    end
  end
  // A locked packet restricts the choice to the current owner, which ptr still names
  always_comb begin
    sel      = (state == HOLD) ? ptr : win;
    do_grant = tx_ready && ((state == IDLE && |req_valid) || (state == HOLD && req_valid[ptr]));
  end
  // Controller sequencing and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= PW'(NUM_REQ - 1);
      lock     <= 1'b0;
      cnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      req_ack  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      req_ack  <= '0;
      err      <= 1'b0;
      if (do_grant) begin
        tx_data  <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
        tx_start <= 1'b1;
        req_ack  <= NUM_REQ'(1) << sel;
        grant    <= NUM_REQ'(1) << sel;
        ptr      <= sel;
        lock     <= ~req_last[sel];
        busy     <= 1'b1;
        state    <= ISSUE;
      end else begin
        case (state)
          ISSUE: begin
            cnt   <= '0;
            state <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (!tx_ready) state <= WAIT_DONE;
            else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
              err   <= 1'b1;
              lock  <= 1'b0;
              grant <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end else cnt <= cnt + 1'b1;
          end
          WAIT_DONE: begin
            if (tx_ready) begin
              if (lock) state <= HOLD;
              else begin
                grant <= '0;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
          IDLE, HOLD: ;
          default: begin
            lock  <= 1'b0;
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter against a round-robin/lock model
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        err;
  int n_chk = 0;
  int n_fail = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BUSY_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    tx_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i] = v;
    req_data[i*8 +: 8] = d;
    req_last[i] = l;
  endtask

  task automatic wait_ack(output logic [3:0] a);
    a = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (req_ack != 0) begin
        a = req_ack;
        break;
      end
    end
  endtask

  task automatic frame();
    tick();
    tx_ready = 1'b0;
    tick();
    tick();
    tx_ready = 1'b1;
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] a;
    logic [3:0] seen;
    logic [7:0] cur_d [4];
    bit         cur_l [4];
    logic [3:0] drv;
    int tc, last_win, acks, pw, fr, w;
    bit locked, err_seen;

    #12;
    chk("reset_outputs", {tx_start, tx_data, req_ack, grant, err, busy}, 0);
    rst_n = 1'b1;

    do_reset();
    set_req(0, 1, 8'hA5, 1);
    tick();
    chk("single_ack", req_ack, 4'b0001);
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_grant", grant, 4'b0001);
    set_req(0, 0, 8'h00, 0);
    tick();
    chk("single_start_drop", {tx_start, req_ack}, 0);
    tx_ready = 1'b0;
    tick();
    chk("single_grant_held", grant, 4'b0001);
    tx_ready = 1'b1;
    tick();
    chk("single_grant_clear", grant, 0);
    chk("single_idle", busy, 0);
    chk("single_data_hold", tx_data, 8'hA5);

    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1, 8'h10 + 8'(i), 1);
    for (int r = 0; r < 6; r++) begin
      wait_ack(a);
      chk("fair_order", a, 32'(1) << (r % 4));
      chk("fair_data", tx_data, 8'h10 + 8'(r % 4));
      frame();
    end
    req_valid = '0;

    do_reset();
    set_req(2, 1, 8'h11, 0);
    wait_ack(a);
    chk("lock_b1", a, 4'b0100);
    chk("lock_b1_data", tx_data, 8'h11);
    set_req(0, 1, 8'h55, 1);
    set_req(2, 1, 8'h22, 0);
    frame();
    wait_ack(a);
    chk("lock_b2", a, 4'b0100);
    chk("lock_b2_data", tx_data, 8'h22);
    set_req(2, 0, 8'h00, 0);
    frame();
    seen = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      seen |= req_ack;
    end
    chk("hold_no_ack", seen, 0);
    chk("hold_busy", busy, 1);
    chk("hold_grant", grant, 4'b0100);
    set_req(2, 1, 8'h33, 1);
    wait_ack(a);
    chk("lock_b3", a, 4'b0100);
    chk("lock_b3_data", tx_data, 8'h33);
    set_req(2, 0, 8'h00, 0);
    frame();
    wait_ack(a);
    chk("lock_then_r0", a, 4'b0001);
    chk("lock_then_r0_data", tx_data, 8'h55);
    set_req(0, 0, 8'h00, 0);
    frame();

    do_reset();
    set_req(1, 1, 8'h77, 1);
    wait_ack(a);
    chk("to_ack", a, 4'b0010);
    set_req(1, 0, 8'h00, 0);
    tc = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (err) begin
        tc = c;
        break;
      end
    end
    chk("to_cycles", tc, 16);
    chk("to_busy", busy, 0);
    chk("to_grant", grant, 0);
    tick();
    chk("to_err_pulse", err, 0);
    set_req(3, 1, 8'h99, 1);
    wait_ack(a);
    chk("to_next_grant", a, 4'b1000);
    chk("to_next_data", tx_data, 8'h99);
    set_req(3, 0, 8'h00, 0);
    frame();

    do_reset();
    set_req(0, 1, 8'h12, 0);
    wait_ack(a);
    chk("rst_pre_ack", a, 4'b0001);
    set_req(0, 1, 8'h34, 1);
    set_req(3, 1, 8'h9A, 1);
    tick();
    tx_ready = 1'b0;
    tick();
    chk("rst_wait_done", {busy, grant}, 5'b1_0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {tx_start, tx_data, req_ack, grant, err, busy}, 0);
    #10;
    rst_n = 1'b1;
    seen = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen |= {3'b000, tx_start} | req_ack;
    end
    chk("rst_no_issue", seen, 0);
    tx_ready = 1'b1;
    wait_ack(a);
    chk("rst_first_r0", a, 4'b0001);
    chk("rst_first_data", tx_data, 8'h34);
    req_valid = '0;
    frame();

    do_reset();
    tx_ready = 1'b0;
    set_req(3, 1, 8'hC3, 1);
    seen = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen |= {3'b000, tx_start} | req_ack;
    end
    chk("rdy_low_no_ack", seen, 0);
    tx_ready = 1'b1;
    tick();
    chk("rdy_ack", req_ack, 4'b1000);
    chk("rdy_start", tx_start, 1);
    chk("rdy_data", tx_data, 8'hC3);
    set_req(3, 0, 8'h00, 0);
    frame();

    do_reset();
    last_win = 3;
    locked = 0;
    acks = 0;
    err_seen = 0;
    pw = 0;
    fr = 0;
    for (int i = 0; i < 4; i++) begin
      cur_d[i] = '0;
      cur_l[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      drv = req_valid;
      tick();
      if (err) err_seen = 1;
      if (req_ack != 0) begin
        w = locked ? last_win : rr_pick(drv, last_win);
        chk("rnd_who", req_ack, 32'(1) << w);
        chk("rnd_data", tx_data, cur_d[w]);
        chk("rnd_start", tx_start, 1);
        chk("rnd_grant", grant, 32'(1) << w);
        last_win = w;
        locked = !cur_l[w];
        acks++;
        req_valid[w] = 1'b0;
      end
      if (tx_start) pw = $urandom_range(1, 3);
      else if (pw > 0) begin
        pw--;
        if (pw == 0) begin
          tx_ready = 1'b0;
          fr = $urandom_range(1, 5);
        end
      end else if (fr > 0) begin
        fr--;
        if (fr == 0) tx_ready = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          cur_d[i] = 8'($urandom);
          cur_l[i] = 1'($urandom_range(0, 1));
          set_req(i, 1, cur_d[i], cur_l[i]);
        end
      end
    end
    chk("rnd_no_err", err_seen, 0);
    chk("rnd_progress", acks >= 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
